// File: rtl/umem_responder.sv
`timescale 1ns/1ps
// Single-outstanding AXI-lite style word memory slave for the CPU memory initiator.
// Every output is a register; all readies are precomputed one cycle ahead from the next state.
module umem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_awaddr,
   input  logic        i_awvalid,
   output logic        o_awready,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   input  logic        i_wvalid,
   output logic        o_wready,
   output logic [1:0]  o_bresp,
   output logic        o_bvalid,
   input  logic        i_bready,
   input  logic [31:0] i_araddr,
   input  logic        i_arvalid,
   output logic        o_arready,
   output logic [31:0] o_rdata,
   output logic [1:0]  o_rresp,
   output logic        o_rvalid,
   input  logic        i_rready
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_W_COLLECT = 3'd1;
   localparam logic [2:0] S_W_EXEC    = 3'd2;
   localparam logic [2:0] S_B_RESP    = 3'd3;
   localparam logic [2:0] S_R_EXEC    = 3'd4;
   localparam logic [2:0] S_R_RESP    = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [2:0]       r_state;
   logic [2:0]       w_nxt;
   logic             r_have_aw;
   logic             r_have_w;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_awready;
   logic             r_wready;
   logic             r_arready;
   logic             r_bvalid;
   logic [1:0]       r_bresp;
   logic             r_rvalid;
   logic [1:0]       r_rresp;
   logic [31:0]      r_rdata;
   logic [31:0]      r_mem [DEPTH_WORDS];

   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_ar_hs;
   logic             w_have_aw_nxt;
   logic             w_have_w_nxt;
   logic             w_ar_go;
   logic             w_awready_nxt;
   logic             w_wready_nxt;
   logic [31:0]      w_off;
   logic [31:0]      w_word;
   logic             w_in_range;
   logic [IDX_W-1:0] w_idx;

   assign w_aw_hs       = i_awvalid & r_awready;
   assign w_w_hs        = i_wvalid & r_wready;
   assign w_ar_hs       = i_arvalid & r_arready;
   assign w_have_aw_nxt = r_have_aw | w_aw_hs;
   assign w_have_w_nxt  = r_have_w | w_w_hs;

   // Range test on the word index keeps the comparison free of 32-bit wrap.
   assign w_off      = r_addr - BASE_ADDR;
   assign w_word     = w_off >> 2;
   assign w_in_range = (r_addr >= BASE_ADDR) && (w_word < DEPTH_WORDS);
   assign w_idx      = w_word[IDX_W-1:0];

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ar_hs)                 w_nxt = S_R_EXEC;
            else if (w_aw_hs && w_w_hs)  w_nxt = S_W_EXEC;
            else if (w_aw_hs || w_w_hs)  w_nxt = S_W_COLLECT;
         end
         S_W_COLLECT: if (w_have_aw_nxt && w_have_w_nxt) w_nxt = S_W_EXEC;
         S_W_EXEC:    w_nxt = S_B_RESP;
         S_B_RESP:    if (r_bvalid && i_bready) w_nxt = S_IDLE;
         S_R_EXEC:    w_nxt = S_R_RESP;
         S_R_RESP:    if (r_rvalid && i_rready) w_nxt = S_IDLE;
         default:     w_nxt = S_IDLE;
      endcase
   end

   // arready is only offered once a read is seen with no write pending, and it
   // withdraws the write readies for that cycle so writes keep priority.
   always_comb begin
      w_ar_go       = (w_nxt == S_IDLE) && i_arvalid && !i_awvalid && !i_wvalid;
      w_awready_nxt = 1'b0;
      w_wready_nxt  = 1'b0;
      if (w_nxt == S_IDLE) begin
         w_awready_nxt = !w_ar_go;
         w_wready_nxt  = !w_ar_go;
      end else if (w_nxt == S_W_COLLECT) begin
         w_awready_nxt = !w_have_aw_nxt;
         w_wready_nxt  = !w_have_w_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_have_aw <= 1'b0;
         r_have_w  <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_arready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_nxt;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_arready <= w_ar_go;
         if (w_aw_hs) begin
            r_addr    <= i_awaddr;
            r_have_aw <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
            r_have_w <= 1'b1;
         end
         if (w_ar_hs) r_addr <= i_araddr;
         case (r_state)
            S_W_EXEC: begin
               r_have_aw <= 1'b0;
               r_have_w  <= 1'b0;
               r_bvalid  <= 1'b1;
               r_bresp   <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            S_B_RESP: if (i_bready) r_bvalid <= 1'b0;
            S_R_EXEC: begin
               r_rvalid <= 1'b1;
               r_rresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
               r_rdata  <= w_in_range ? r_mem[w_idx] : '0;
            end
            S_R_RESP: if (i_rready) r_rvalid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge i_clk) begin
      if (!i_reset && (r_state == S_W_EXEC) && w_in_range) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end

   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_arready = r_arready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;
   assign o_rvalid  = r_rvalid;
   assign o_rresp   = r_rresp;
   assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_umem_responder.sv
`timescale 1ns/1ps
// Random and directed transactions against a word-array model; a negedge monitor
// pops expected responses from queues when the DUT completes B or R handshakes.
module tb_umem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_awaddr, i_wdata, i_araddr;
   logic [3:0]  i_wstrb;
   logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
   logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
   logic [1:0]  o_bresp, o_rresp;
   logic [31:0] o_rdata;

   always #5 clk = ~clk;

   umem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
      .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
      .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready)
   );

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];
   bit   [31:0] mdl [int unsigned];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      longint unsigned x = a;
      longint unsigned b = BASE;
      return (x >= b) && (x < b + 64'(4 * DEPTH));
   endfunction

   function automatic int unsigned widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // Response monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (o_bvalid && i_bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", {62'd0, o_bresp}, 64'hFFFF);
            else chk("bresp", o_bresp, exp_b.pop_front());
         end
         if (o_rvalid && i_rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", {30'd0, o_rresp, o_rdata}, 64'hFFFF_FFFF_FFFF);
            else chk("rresp_rdata", {o_rresp, o_rdata}, exp_r.pop_front());
         end
      end
   end

   // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int skew, input int bdel);
      bit aw_done = 0, w_done = 0, done = 0;
      int n = 0, hs_cyc = 0, first_v = -1;
      logic [1:0] eb;
      bit [31:0] w;
      eb = in_rng(a) ? 2'b00 : 2'b10;
      if (in_rng(a) && s != 4'b0000) begin
         w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
         for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
         mdl[widx(a)] = w;
      end
      exp_b.push_back(eb);
      i_awaddr = a; i_wdata = d; i_wstrb = s;
      i_wvalid = (skew >= 0); i_awvalid = (skew <= 0);
      while (!(aw_done && w_done) && n < 40) begin
         @(negedge clk);
         if (w_done && !aw_done) chk("wready_low_in_collect", o_wready, 0);
         if (aw_done && !w_done) chk("awready_low_in_collect", o_awready, 0);
         if (i_arvalid) chk("arready_low_for_write", o_arready, 0);
         if (i_awvalid && o_awready) aw_done = 1;
         if (i_wvalid && o_wready) w_done = 1;
         hs_cyc = cyc;
         @(posedge clk); #1;
         if (aw_done) i_awvalid = 0;
         if (w_done) i_wvalid = 0;
         n++;
         if (!aw_done && n == skew) i_awvalid = 1;
         if (!w_done && n == -skew) i_wvalid = 1;
      end
      chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
      i_awvalid = 0; i_wvalid = 0;
      i_bready = (bdel == 0);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         if (o_bvalid && first_v < 0) first_v = cyc;
         if (o_bvalid && !i_bready) chk("bresp_hold", o_bresp, eb);
         if (i_arvalid) chk("arready_low_for_write", o_arready, 0);
         done = o_bvalid && i_bready;
         @(posedge clk); #1;
         if (first_v >= 0 && (cyc - first_v) >= bdel) i_bready = 1;
         n++;
      end
      i_bready = 0;
      chk("b_latency", first_v, hs_cyc + 2);
   endtask

   task automatic rd(input logic [31:0] a, input int rdel);
      bit done = 0;
      int n = 0, hs_cyc = 0, first_v = -1;
      logic [33:0] er;
      er = in_rng(a) ? {2'b00, mdl[widx(a)]} : {2'b10, 32'h0};
      exp_r.push_back(er);
      i_araddr = a; i_arvalid = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         done = o_arready;
         hs_cyc = cyc;
         @(posedge clk); #1;
         n++;
      end
      chk("ar_accepted", done, 1);
      i_arvalid = 0;
      i_rready = (rdel == 0);
      done = 0; n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         if (o_rvalid && first_v < 0) first_v = cyc;
         if (o_rvalid && !i_rready) chk("r_hold", {o_rresp, o_rdata}, er);
         done = o_rvalid && i_rready;
         @(posedge clk); #1;
         if (first_v >= 0 && (cyc - first_v) >= rdel) i_rready = 1;
         n++;
      end
      i_rready = 0;
      chk("r_latency", first_v, hs_cyc + 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int sel;
      reset = 1;
      i_awaddr = '0; i_wdata = '0; i_araddr = '0; i_wstrb = '0;
      i_awvalid = 0; i_wvalid = 0; i_bready = 0; i_arvalid = 0; i_rready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_readies", {o_awready, o_wready, o_arready}, 3'b000);
      chk("reset_valids", {o_bvalid, o_rvalid}, 2'b00);
      chk("reset_resp", {o_bresp, o_rresp, o_rdata}, 36'h0);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_readies", {o_awready, o_wready, o_arready}, 3'b110);
      @(posedge clk); #1;

      // Basic write/read, byte-lane merge, W-before-AW and AW-before-W collection
      wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      rd(32'h10, 0);
      wr(32'h20, 32'h11223344, 4'hF, 0, 0);
      wr(32'h20, 32'hAABBCCDD, 4'b0100, 0, 1);
      rd(32'h20, 0);
      wr(32'h30, 32'h5A5A_A5A5, 4'hF, 4, 0);
      rd(32'h30, 1);
      wr(32'h00, 32'h0BAD_F00D, 4'hF, -3, 2);

      // Simultaneous AW, W and AR: write first, read returns the new data
      i_araddr = 32'h30; i_arvalid = 1;
      wr(32'h30, 32'h1234_5678, 4'hF, 0, 1);
      rd(32'h30, 0);

      // Range boundaries, SLVERR without aliasing, zero strobes
      wr(32'hFFC, 32'hCAFE_0FFC, 4'hF, 0, 0);
      rd(32'hFFF, 0);
      rd(32'h1000, 6);
      wr(32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 0);
      wr(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1, 0);
      wr(32'h1000, 32'hFFFF_FFFF, 4'h0, 0, 0);
      wr(32'h10, 32'h0000_0000, 4'h0, 0, 0);
      rd(32'h00, 0);
      rd(32'h10, 0);
      rd(32'h8000_0000, 3);

      // Randomized traffic over words 0..15 and the last word, plus out-of-range
      for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF, 0, 0);
      for (int k = 0; k < 80; k++) begin
         sel = $urandom_range(0, 9);
         if (sel == 9) a = 32'h1000 | $urandom;
         else if (sel == 8) a = 32'hFFC;
         else a = 32'($urandom_range(0, 15) * 4);
         a[1:0] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 3));
         else
            rd(a, $urandom_range(0, 3));
      end

      // Reset while holding a captured AW with no W
      i_awaddr = 32'h3C; i_wdata = 32'hFFFF_FFFF; i_wstrb = 4'hF; i_awvalid = 1;
      sel = 0;
      for (int n = 0; n < 10 && sel == 0; n++) begin
         @(negedge clk);
         sel = o_awready ? 1 : 0;
         @(posedge clk); #1;
      end
      i_awvalid = 0;
      chk("abort_aw_accepted", sel, 1);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      i_wvalid = 1;
      @(negedge clk);
      chk("abort_readies_in_reset", {o_awready, o_wready, o_arready, o_bvalid}, 4'b0000);
      @(posedge clk); #1;
      i_wvalid = 0;
      reset = 0;
      i_bready = 1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("abort_no_bvalid", o_bvalid, 0);
         @(posedge clk); #1;
      end
      i_bready = 0;
      rd(32'h3C, 0);

      repeat (3) @(posedge clk);
      chk("queues_drained", exp_b.size() + exp_r.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
